// File: rtl/board_link_pkg.sv
// rtl/board_link_pkg.sv - shared types, defaults and width helpers for the board link transmitter
//
// Purpose: state encoding for the board link transmitter FSM, default
// parameter values and helpers that size the counter and read address.
// Ports: none (package).
package board_link_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DRIVE,
    RELEASE,
    FETCH,
    DONE
  } state_t;

  localparam int         DEF_DATA_W      = 4;
  localparam int         DEF_CELLS       = 81;
  localparam logic [3:0] DEF_HEADER_WORD = 4'hA;

  // Word counter must be able to hold CELLS itself (it saturates there).
  function automatic int cnt_width(input int cells);
    return $clog2(cells + 1);
  endfunction

  // Grid address width; at least one bit so a single-cell grid still has a port.
  function automatic int addr_width(input int cells);
    return (cells > 1) ? $clog2(cells) : 1;
  endfunction

endpackage

// File: rtl/link_sync.sv
// rtl/link_sync.sv - multi-stage bit synchroniser with asynchronous reset
//
// Purpose: brings an asynchronous level into the clk domain.
// Ports:
//   clk - system clock
//   rst - asynchronous active-high reset, clears every stage
//   d   - asynchronous input level
//   q   - synchronised level (last stage)
module link_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/board_link_tx.sv
// rtl/board_link_tx.sv - inter-board grid link transmitter (header + CELLS words, four-phase handshake)
//
// Purpose: on a peer request, sends HEADER_WORD followed by CELLS grid words
// read from the local grid store, each over a four-phase valid/ack handshake.
// Withdrawing the request mid-transfer aborts it.
// Optional macro BOARD_LINK_TIMEOUT_EN adds a per-phase handshake timeout and
// the sticky timeout_err output.
// Ports:
//   clk, rst     - clock, asynchronous active-high reset
//   request      - asynchronous peer request level
//   ack_in       - asynchronous peer acknowledge
//   ack_out      - request accepted, held until the request is withdrawn
//   data, valid  - offered word and its qualifier
//   rd_addr      - grid read address; rd_data returns RD_LAT cycles later
//   busy         - not idle
//   done, abort  - one-cycle completion / early-termination pulses
//   timeout_err  - sticky handshake timeout flag (BOARD_LINK_TIMEOUT_EN only)
module board_link_tx
  import board_link_pkg::*;
#(
  parameter int                DATA_W      = DEF_DATA_W,
  parameter int                CELLS       = DEF_CELLS,
  parameter logic [DATA_W-1:0] HEADER_WORD = DEF_HEADER_WORD,
  parameter int                RD_LAT      = 1,
  parameter int                SYNC_STAGES = 2,
  parameter int                TIMEOUT     = 1000000,
  localparam int               AW          = addr_width(CELLS),
  localparam int               CW          = cnt_width(CELLS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              request,
  input  logic              ack_in,
  output logic              ack_out,
  output logic [DATA_W-1:0] data,
  output logic              valid,
  output logic [AW-1:0]     rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              done,
  output logic              abort
`ifdef BOARD_LINK_TIMEOUT_EN
  ,
  output logic              timeout_err
`endif
);

  logic request_s, ack_s;

  link_sync #(.STAGES(SYNC_STAGES)) u_sync_req (
    .clk(clk), .rst(rst), .d(request), .q(request_s)
  );

  link_sync #(.STAGES(SYNC_STAGES)) u_sync_ack (
    .clk(clk), .rst(rst), .d(ack_in), .q(ack_s)
  );

  state_t            state, state_n;
  logic [CW-1:0]     cnt, cnt_n;
  logic [1:0]        lat, lat_n;
  logic [AW-1:0]     rd_addr_n;
  logic [DATA_W-1:0] data_n;
  logic              valid_n, ack_out_n, done_n, abort_n;
  logic              quit;

`ifdef BOARD_LINK_TIMEOUT_EN
  logic [31:0] timer, timer_n;
  logic        tmo_hit, timeout_err_n;
`else
  // Handshakes wait indefinitely; TIMEOUT has no effect in this build.
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT > 0);
`endif

  assign busy = (state != IDLE);

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    lat_n     = lat;
    rd_addr_n = rd_addr;
    data_n    = data;
    valid_n   = valid;
    ack_out_n = ack_out;
    done_n    = 1'b0;
    abort_n   = 1'b0;

    case (state)
      IDLE: begin
        if (request_s) begin
          state_n   = DRIVE;
          ack_out_n = 1'b1;
          data_n    = HEADER_WORD;
          valid_n   = 1'b1;
          cnt_n     = '0;
        end
      end
      DRIVE: begin
        if (ack_s) begin
          valid_n = 1'b0;
          state_n = RELEASE;
        end
      end
      RELEASE: begin
        if (!ack_s) begin
          if (cnt == CW'(CELLS)) begin
            state_n = DONE;
            done_n  = 1'b1;
          end else begin
            rd_addr_n = cnt[AW-1:0];
            lat_n     = '0;
            state_n   = FETCH;
          end
        end
      end
      FETCH: begin
        // lat counts the cycles since rd_addr moved; rd_data is good once it reaches RD_LAT.
        if (lat == 2'(RD_LAT)) begin
          data_n  = rd_data;
          valid_n = 1'b1;
          cnt_n   = (cnt == CW'(CELLS)) ? cnt : cnt + 1'b1;
          state_n = DRIVE;
        end else begin
          lat_n = lat + 1'b1;
        end
      end
      DONE: begin
        valid_n = 1'b0;
        if (!request_s) begin
          ack_out_n = 1'b0;
          state_n   = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase

    // Withdrawal (or timeout) overrides whatever the handshake step decided,
    // including a simultaneous ack in DRIVE.
    quit = (state == DRIVE || state == RELEASE || state == FETCH) && !request_s;
`ifdef BOARD_LINK_TIMEOUT_EN
    tmo_hit = (state == DRIVE || state == RELEASE) && (timer == 32'(TIMEOUT - 1));
    quit    = quit || tmo_hit;
`endif
    if (quit) begin
      state_n   = IDLE;
      valid_n   = 1'b0;
      ack_out_n = 1'b0;
      abort_n   = 1'b1;
      done_n    = 1'b0;
      data_n    = data;
      rd_addr_n = rd_addr;
      cnt_n     = cnt;
      lat_n     = lat;
    end

`ifdef BOARD_LINK_TIMEOUT_EN
    // Phase timer restarts on every state change and only runs while waiting on the peer.
    if (state_n != state) begin
      timer_n = '0;
    end else if (state == DRIVE || state == RELEASE) begin
      timer_n = timer + 1'b1;
    end else begin
      timer_n = timer;
    end
    timeout_err_n = timeout_err;
    if (tmo_hit) begin
      timeout_err_n = 1'b1;
    end else if (state == IDLE && state_n == DRIVE) begin
      timeout_err_n = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      lat     <= '0;
      rd_addr <= '0;
      data    <= '0;
      valid   <= 1'b0;
      ack_out <= 1'b0;
      done    <= 1'b0;
      abort   <= 1'b0;
`ifdef BOARD_LINK_TIMEOUT_EN
      timer       <= '0;
      timeout_err <= 1'b0;
`endif
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      lat     <= lat_n;
      rd_addr <= rd_addr_n;
      data    <= data_n;
      valid   <= valid_n;
      ack_out <= ack_out_n;
      done    <= done_n;
      abort   <= abort_n;
`ifdef BOARD_LINK_TIMEOUT_EN
      timer       <= timer_n;
      timeout_err <= timeout_err_n;
`endif
    end
  end

endmodule

// File: doc/board_link_tx.md
Name: board_link_tx

Overview:
- Parametrised transmitter for the inter-board grid link.
- On a peer request, it sends one header word followed by CELLS grid words over a four-phase valid/ack handshake.
- Generalises the fixed 4-bit, 81-cell board exchange in four ways: configurable word width, cell count, read latency and header value, plus abort-on-withdraw handling.
- Sits between the local grid store (read port) and the board-to-board pins.

Parameters:
- DATA_W, 4: width of each transferred word and of rd_data.
- CELLS, 81: number of grid words sent after the header; must be ≥ 1.
- HEADER_WORD, 4'hA: value of the first word; DATA_W bits wide.
- RD_LAT, 1: grid read latency in cycles (0..2); rd_data is valid RD_LAT cycles after rd_addr changes.
- SYNC_STAGES, 2: flip-flop stages on request and ack_in; must be ≥ 2.
- TIMEOUT, 1000000: cycles allowed per handshake phase. Used only with the optional feature.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- request  in  1  peer asks for the grid; asynchronous, level
- ack_in  in  1  peer acknowledge; asynchronous, four-phase
- ack_out  out  1  request accepted; high from transfer start until request is withdrawn
- data  out  DATA_W  current word; stable while valid=1
- valid  out  1  word on data is offered
- rd_addr  out  $clog2(CELLS)  grid read address
- rd_data  in  DATA_W  grid read data
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse when the last word completes its handshake
- abort  out  1  one-cycle pulse when the transfer ends early

Behaviour:
- Reset values (rst=1, asynchronous): state IDLE, ack_out=0, valid=0, data=0, rd_addr=0, busy=0, done=0, abort=0, cnt=0, synchronisers cleared.
- Synchronisation: request_s and ack_s are the last stage of the SYNC_STAGES chains. All decisions below use only request_s and ack_s.
- IDLE → DRIVE when request_s=1. On that edge: ack_out←1, data←HEADER_WORD, valid←1, cnt←0.
- DRIVE: hold data and valid. When ack_s=1: valid←0, go to RELEASE.
- RELEASE: wait for ack_s=0.
  - If cnt==CELLS, go to DONE and pulse done.
  - Otherwise rd_addr←cnt, go to FETCH.
- FETCH: lasts RD_LAT+1 cycles. On the final cycle: data←rd_data, valid←1, cnt←cnt+1, go to DRIVE.
- DONE: ack_out stays 1 and valid=0. When request_s=0: ack_out←0, go to IDLE.
- Word order and count:
  - Word 0 is the header. Word k (1..CELLS) is grid cell k-1.
  - Exactly CELLS+1 valid rising edges occur per complete transfer.
- cnt width is $clog2(CELLS+1). It never wraps; the counter saturates at CELLS.
- Request withdrawn: if request_s=0 in DRIVE, RELEASE or FETCH, then valid←0, ack_out←0, abort pulses, go to IDLE. Partial data is discarded.
- Simultaneous events: in DRIVE, if ack_s=1 and request_s=0 in the same cycle, abort has priority.
- Request held high after DONE: no retransmit. A new transfer needs request_s to fall and then rise again.
- Reset mid-transfer: immediate return to reset values. Because valid and ack_out drop, the peer sees the transfer withdrawn.
- Latency: the first valid rises SYNC_STAGES+1 cycles after request goes high, counted from its first sampling edge. Each subsequent word adds RD_LAT+1 cycles on top of the peer's handshake time.
- rd_addr holds its value outside FETCH.

Optional Feature:
- Macro: BOARD_LINK_TIMEOUT_EN.
- With the macro defined:
  - A phase counter clears on every state change.
  - If the block stays in DRIVE or RELEASE for TIMEOUT cycles, it takes the abort path (abort pulses, back to IDLE) and sets a sticky output port timeout_err.
  - timeout_err is cleared by rst or by the next IDLE→DRIVE transition.
- Without the macro: timeout_err does not exist and handshakes wait indefinitely.

Decomposition:
- Shared package board_link_pkg:
  - state enum: IDLE, DRIVE, RELEASE, FETCH, DONE
  - default HEADER_WORD, CELLS=81, DATA_W=4
  - a function returning the counter width
- One natural sub-module: link_sync. It is a SYNC_STAGES-deep bit synchroniser with asynchronous reset, instantiated for request and ack_in.

Test Plan:
- Full transfer, grid cells i=0..80 holding (i%9)+1, peer acks after 3 cycles and releases after 3 cycles → data sequence 0xA, 1, 2, …, 9, 1, …; 82 valid pulses; done pulses once; ack_out held until request drops.
- RD_LAT=2, CELLS=4, DATA_W=8, rd_data=addr+0x10 → words HEADER, 0x10, 0x11, 0x12, 0x13. Each FETCH lasts exactly 3 cycles, checked by cycle count from ack_s fall to valid rise.
- Request dropped while word 40 is in DRIVE → valid=0 and ack_out=0 within SYNC_STAGES+1 cycles, abort pulses once, done never pulses; a later request restarts from the header.
- Request held high after done, then toggled → no second transfer until the fall and rise; the second transfer is complete and correct.
- rst asserted during RELEASE of word 10 → all outputs are 0 in the same cycle (asynchronous). After rst drops with request high, the transfer restarts with the header.
- With BOARD_LINK_TIMEOUT_EN and TIMEOUT=50, peer never acks → exactly 50 cycles after valid rises, abort pulses, timeout_err=1 and valid=0; the next request clears timeout_err.
